// File: rtl/cpu_pkg.sv
// Shared constants for the CPU counter family: direction/mode encodings and
// the default prescaler width.
package cpu_pkg;

    localparam logic CNT_DN   = 1'b0;
    localparam logic CNT_UP   = 1'b1;
    localparam logic CNT_WRAP = 1'b0;
    localparam logic CNT_SAT  = 1'b1;

    localparam int unsigned CNT_PRESCALE_W_DEF = 8;

endpackage

// File: rtl/cpu_prescaler.sv
// Tick generator: counts enabled cycles 0..limit_i and emits a combinational
// tick on the cycle the count has reached (or passed) the limit.
module cpu_prescaler
    import cpu_pkg::*;
#(
    parameter int unsigned PRESCALE_W = CNT_PRESCALE_W_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  restart_i,
    input  logic [PRESCALE_W-1:0] limit_i,
    output logic                  tick_c_o
);

    logic [PRESCALE_W-1:0] cnt_q, cnt_d;

    // A count already above a freshly lowered limit ticks and restarts.
    always_comb begin
        cnt_d    = cnt_q;
        tick_c_o = 1'b0;
        if (restart_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            if (cnt_q >= limit_i) begin
                tick_c_o = 1'b1;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + PRESCALE_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cpu_counter_mod.sv
// Parametrised up/down modulo counter with load, wrap/saturate, tc pulse and
// sticky overflow. Optional prescaler enabled by CPU_COUNTER_PRESCALE_EN.
module cpu_counter_mod
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned MAX_VAL    = 2**WIDTH - 1,
    parameter int unsigned RST_VAL    = 0,
    parameter int unsigned PRESCALE_W = CNT_PRESCALE_W_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  up_i,
    input  logic                  sat_i,
    input  logic                  load_i,
    input  logic [WIDTH-1:0]      load_val_i,
    input  logic                  clr_ovf_i,
`ifdef CPU_COUNTER_PRESCALE_EN
    input  logic [PRESCALE_W-1:0] prescale_i,
`endif
    output logic [WIDTH-1:0]      count_o,
    output logic                  tc_o,
    output logic                  ovf_o,
    output logic                  zero_o
);

    localparam int unsigned XW = WIDTH + 1;
    localparam logic [XW-1:0]    MAX_X = XW'(MAX_VAL);
    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RST_C = WIDTH'(RST_VAL);

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             step_c;
    logic             bound_c;
    logic [XW-1:0]    inc_x, dec_x, load_x;

`ifdef CPU_COUNTER_PRESCALE_EN
    logic tick_c;

    cpu_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .en_i      (en_i),
        .restart_i (load_i),
        .limit_i   (prescale_i),
        .tick_c_o  (tick_c)
    );

    assign step_c = en_i & tick_c;
`else
    localparam int unsigned unused_prescale_w = PRESCALE_W;

    assign step_c = en_i;
`endif

    // Extended arithmetic: the carry/borrow bit exposes the boundary directly.
    assign inc_x  = {1'b0, count_q} + XW'(1);
    assign dec_x  = {1'b0, count_q} - XW'(1);
    assign load_x = {1'b0, load_val_i};

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        ovf_d   = ovf_q;
        bound_c = 1'b0;
        if (load_i) begin
            count_d = (load_x > MAX_X) ? MAX_C : load_val_i;
        end else if (step_c) begin
            if (up_i == CNT_UP) begin
                if (inc_x > MAX_X) begin
                    bound_c = 1'b1;
                    count_d = (sat_i == CNT_SAT) ? MAX_C : '0;
                end else begin
                    count_d = inc_x[WIDTH-1:0];
                end
            end else begin
                if (dec_x[WIDTH]) begin
                    bound_c = 1'b1;
                    count_d = (sat_i == CNT_SAT) ? '0 : MAX_C;
                end else begin
                    count_d = dec_x[WIDTH-1:0];
                end
            end
        end
        tc_d = bound_c;
        // A boundary event on the same edge as a clear keeps the flag set.
        if (clr_ovf_i) begin
            ovf_d = 1'b0;
        end
        if (bound_c) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count_q <= RST_C;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = tc_q;
    assign ovf_o   = ovf_q;
    assign zero_o  = (count_q == '0);

endmodule

// File: doc/cpu_counter_mod.md
Name: cpu_counter_mod

Overview:
- Parametrised successor to the fixed 4-bit CPU counter.
- Configurable width and modulo limit, up/down direction, synchronous load, wrap or saturate mode, terminal-count pulse and sticky overflow flag.
- Instantiated under cpu_top as the general-purpose CPU tick/cycle counter; the 4-bit free-running case is WIDTH=4, MAX_VAL=15, en_i=1, up_i=1, sat_i=0.

Parameters:
WIDTH, 4, counter width in bits (>=2)
MAX_VAL, 2**WIDTH-1, terminal value; count range 0..MAX_VAL; 1 <= MAX_VAL <= 2**WIDTH-1
RST_VAL, 0, count value on reset; must be <= MAX_VAL
PRESCALE_W, 8, prescaler width (used only with CPU_COUNTER_PRESCALE_EN)

Ports:
clk_i  input  1  clock, all state on rising edge
rst_i  input  1  reset, asynchronous assert, active-low (0 = reset)
en_i  input  1  count enable (one step per enabled cycle)
up_i  input  1  direction: 1 = increment, 0 = decrement
sat_i  input  1  mode: 1 = saturate at bounds, 0 = wrap modulo MAX_VAL+1
load_i  input  1  synchronous load strobe
load_val_i  input  WIDTH  value loaded when load_i=1
clr_ovf_i  input  1  clears ovf_o
count_o  output  WIDTH  current count (registered)
tc_o  output  1  one-cycle registered pulse on a boundary event
ovf_o  output  1  sticky boundary-event flag (registered)
zero_o  output  1  combinational, count_o == 0

Behaviour:
- Reset (rst_i=0, asynchronous): count_o=RST_VAL, tc_o=0, ovf_o=0, prescaler=0. Deassertion is synchronised externally; the block makes no assumption beyond that.
- Priority per edge: load_i > step (en_i, gated by prescaler tick if enabled) > hold.
- Load:
  - count_o <= min(load_val_i, MAX_VAL); loads above MAX_VAL clamp to MAX_VAL.
  - No tc_o pulse. Prescaler counter restarts at 0.
- Step, up:
  - count < MAX_VAL: count+1.
  - count == MAX_VAL: wrap mode -> 0; saturate mode -> hold MAX_VAL. Either way this is a boundary event.
- Step, down:
  - count > 0: count-1.
  - count == 0: wrap mode -> MAX_VAL; saturate mode -> hold 0. Boundary event.
- Boundary event:
  - tc_o=1 for the single cycle after the edge that attempted the step.
  - ovf_o set on the same edge.
  - Saturate mode with en_i held at the bound: tc_o pulses every enabled cycle.
- Latency: count_o, tc_o and ovf_o change one edge after inputs are sampled. zero_o tracks count_o combinationally.
- clr_ovf_i clears ovf_o on the next edge. Set and clear on the same edge: set wins (ovf_o=1).
- Direction and mode changes take effect on the next enabled step; no internal state depends on them.
- Arithmetic is done at WIDTH+1 bits internally. No out-of-range value ever appears on count_o when MAX_VAL < 2**WIDTH-1.

Optional Feature:
- CPU_COUNTER_PRESCALE_EN defined:
  - Adds input prescale_i [PRESCALE_W]. An internal prescaler counts enabled cycles 0..prescale_i and emits a tick on reaching prescale_i.
  - A step occurs only on a tick, i.e. one step per prescale_i+1 enabled cycles; prescale_i=0 behaves as undefined-macro.
  - prescale_i changed mid-count applies at the next comparison. If the prescaler is already above the new value, it ticks and restarts.
- Undefined: no prescale_i port, no prescaler logic; every enabled cycle steps.

Decomposition:
- Package cpu_pkg (shared): direction constants CNT_DN/CNT_UP, mode constants CNT_WRAP/CNT_SAT, default PRESCALE_W.
- One sub-module: cpu_prescaler (PRESCALE_W-bit tick generator with enable and sync restart). Instantiated only under CPU_COUNTER_PRESCALE_EN.
- cpu_top instantiates cpu_counter_mod with WIDTH=4 in place of the fixed counter.

Test Plan:
- Reset/wrap up: WIDTH=4, MAX_VAL=9, release rst_i, en_i=1, up_i=1, sat_i=0 for 12 cycles -> count_o 0..9, 0, 1. tc_o high exactly the cycle count_o shows 0 after 9. ovf_o=1 thereafter.
- Down saturate: load 2, up_i=0, sat_i=1, en_i=1 for 5 cycles -> count_o 2,1,0,0,0. tc_o pulses on each of the last 2 steps. zero_o=1 from the third value.
- Load clamp and priority: MAX_VAL=9, load_i=1 with load_val_i=14 and en_i=1 -> count_o=9, no tc_o. Next cycle step up in wrap mode -> 0 with tc_o=1.
- Overflow set/clear race: force a boundary event on the same edge as clr_ovf_i=1 -> ovf_o=1. clr_ovf_i alone next cycle -> ovf_o=0.
- Async reset mid-count: count_o=7, drop rst_i between edges -> count_o=RST_VAL, tc_o=0, ovf_o=0 immediately, without waiting for a clock edge.
- Prescale (macro defined): prescale_i=3, en_i=1, up for 16 cycles -> 4 steps, count_o 0 to 4. prescale_i=0 -> step every cycle.
